// File: rtl/preg_arbiter_pkg.sv
// Shared types and constants for the peripheral register port arbiter.
package preg_pkg;

    localparam int PREG_AW = 6;
    localparam int PREG_DW = 16;

    localparam logic [PREG_AW-1:0] REG_DONE    = 6'h21;
    localparam logic [PREG_AW-1:0] REG_PRACUJE = 6'h22;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2,
        RESP    = 2'd3
    } preg_state_e;

endpackage

// File: rtl/preg_arbiter_rr_pick.sv
// Two-way request picker: round-robin on ties, or fixed m0 priority when
// PREG_ARB_FIXED_PRIO_EN is defined.
module preg_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant,
    output logic       gnt_id
);

`ifdef PREG_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        grant  = 2'b00;
        gnt_id = 1'b0;
        if (req[0]) begin
            grant = 2'b01;
        end else if (req[1]) begin
            grant  = 2'b10;
            gnt_id = 1'b1;
        end
    end
`else
    always_comb begin
        grant  = 2'b00;
        gnt_id = 1'b0;
        if (req == 2'b11) begin
            // Tie goes to whoever was not granted last time
            gnt_id = ~last;
            grant  = last ? 2'b01 : 2'b10;
        end else if (req[0]) begin
            grant = 2'b01;
        end else if (req[1]) begin
            grant  = 2'b10;
            gnt_id = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/preg_arbiter.sv
// Serialises two requesters onto the FIR peripheral register port.
// Optional macro PREG_ARB_FIXED_PRIO_EN selects fixed m0 priority.
import preg_pkg::*;

module preg_arbiter #(
    parameter int                 RD_LAT   = 6,
    parameter logic [PREG_AW-1:0] RO_ADDR0 = REG_DONE,
    parameter logic [PREG_AW-1:0] RO_ADDR1 = REG_PRACUJE
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    input  logic               m0_req,
    input  logic               m0_wr,
    input  logic [PREG_AW-1:0] m0_addr,
    input  logic [PREG_DW-1:0] m0_wdata,
    output logic               m0_ack,
    output logic               m0_err,
    output logic [PREG_DW-1:0] m0_rdata,
    input  logic               m1_req,
    input  logic               m1_wr,
    input  logic [PREG_AW-1:0] m1_addr,
    input  logic [PREG_DW-1:0] m1_wdata,
    output logic               m1_ack,
    output logic               m1_err,
    output logic [PREG_DW-1:0] m1_rdata,
    output logic [PREG_AW-1:0] p_address,
    output logic [PREG_DW-1:0] p_data,
    output logic               p_wr,
    input  logic [PREG_DW-1:0] p_data_back,
    output logic               busy
);

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

    preg_state_e        state_q, state_d;
    logic               id_q, id_d;
    logic               wr_q, wr_d;
    logic               err_q, err_d;
    logic [PREG_AW-1:0] addr_q, addr_d;
    logic [PREG_DW-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PREG_AW-1:0] p_address_q, p_address_d;
    logic [PREG_DW-1:0] p_data_q, p_data_d;
    logic               p_wr_q, p_wr_d;
    logic               m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
    logic               m0_err_q, m0_err_d, m1_err_q, m1_err_d;
    logic [PREG_DW-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
    logic               busy_q, busy_d;
    logic [1:0]         grant;
    logic               gnt_id;
    logic               last;

`ifdef PREG_ARB_FIXED_PRIO_EN
    assign last = 1'b0;
`else
    logic last_q, last_d;
    assign last = last_q;

    always_comb begin
        last_d = last_q;
        if (state_q == IDLE && grant != 2'b00) begin
            last_d = gnt_id;
        end
    end

    // Reset to 1 so that m0 wins the first tie
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) last_q <= 1'b1;
        else          last_q <= last_d;
    end
`endif

    preg_rr_pick u_pick (
        .req    ({m1_req, m0_req}),
        .last   (last),
        .grant  (grant),
        .gnt_id (gnt_id)
    );

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        wr_d        = wr_q;
        err_d       = err_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        p_address_d = p_address_q;
        p_data_d    = p_data_q;
        p_wr_d      = 1'b0;
        m0_ack_d    = 1'b0;
        m1_ack_d    = 1'b0;
        m0_err_d    = 1'b0;
        m1_err_d    = 1'b0;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant != 2'b00) begin
                    id_d    = gnt_id;
                    wr_d    = gnt_id ? m1_wr    : m0_wr;
                    addr_d  = gnt_id ? m1_addr  : m0_addr;
                    wdata_d = gnt_id ? m1_wdata : m0_wdata;
                    err_d   = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                p_address_d = addr_q;
                if (wr_q) begin
                    if (addr_q == RO_ADDR0 || addr_q == RO_ADDR1) begin
                        err_d = 1'b1;
                    end else begin
                        p_data_d = wdata_q;
                        p_wr_d   = 1'b1;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d   = '0;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                // Read data has crossed the CDC path once the counter expires
                if (cnt_q == CNT_LAST) begin
                    if (id_q) m1_rdata_d = p_data_back;
                    else      m0_rdata_d = p_data_back;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (id_q) begin
                    m1_ack_d = 1'b1;
                    m1_err_d = err_q;
                end else begin
                    m0_ack_d = 1'b1;
                    m0_err_d = err_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            id_q        <= 1'b0;
            wr_q        <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            p_address_q <= '0;
            p_data_q    <= '0;
            p_wr_q      <= 1'b0;
            m0_ack_q    <= 1'b0;
            m1_ack_q    <= 1'b0;
            m0_err_q    <= 1'b0;
            m1_err_q    <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            wr_q        <= wr_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            p_address_q <= p_address_d;
            p_data_q    <= p_data_d;
            p_wr_q      <= p_wr_d;
            m0_ack_q    <= m0_ack_d;
            m1_ack_q    <= m1_ack_d;
            m0_err_q    <= m0_err_d;
            m1_err_q    <= m1_err_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign m0_ack    = m0_ack_q;
    assign m0_err    = m0_err_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_ack    = m1_ack_q;
    assign m1_err    = m1_err_q;
    assign m1_rdata  = m1_rdata_q;
    assign p_address = p_address_q;
    assign p_data    = p_data_q;
    assign p_wr      = p_wr_q;
    assign busy      = busy_q;

endmodule
